// File: rtl/truth_table_sweeper_if.sv
// Signal bundle between the truth-table sweeper and the game logic / gate selector.
// Optional SWEEP_SCORE_EN adds the running match score.
interface truth_table_sweeper_if;
    logic       start;
    logic [3:0] selection_in;
    logic [3:0] target;
    logic       gate_out;
    logic [3:0] sel_out;
    logic [1:0] gate_in;
    logic       busy;
    logic       done;
    logic [3:0] truth_table;
    logic       match;
`ifdef SWEEP_SCORE_EN
    logic [7:0] score;
`endif

    // Sweeper side
    modport slave (
        input  start, selection_in, target, gate_out,
        output sel_out, gate_in, busy, done, truth_table, match
`ifdef SWEEP_SCORE_EN
        , output score
`endif
    );

    // Controller / selector side
    modport master (
        output start, selection_in, target, gate_out,
        input  sel_out, gate_in, busy, done, truth_table, match
`ifdef SWEEP_SCORE_EN
        , input score
`endif
    );
endinterface

// File: rtl/truth_table_sweeper.sv
// Steps a gate selector through inputs 00..11, samples its output into a truth table and
// compares against a target. Optional SWEEP_SCORE_EN adds a saturating match counter.
module truth_table_sweeper #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input logic                clk,
    input logic                reset,
    truth_table_sweeper_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StSettle, StSample, StDone} state_e;

    localparam logic [3:0] CntLast = 4'(SETTLE_CYCLES - 1);

    state_e     state_q, state_d;
    logic [3:0] sel_q, sel_d;
    logic [3:0] target_q, target_d;
    logic [1:0] gate_in_q, gate_in_d;
    logic [3:0] table_q, table_d;
    logic       match_q, match_d;
    logic [1:0] idx_q, idx_d;
    logic [3:0] cnt_q, cnt_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
`ifdef SWEEP_SCORE_EN
    logic [7:0] score_q, score_d;
`endif

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        target_d  = target_q;
        gate_in_d = gate_in_q;
        table_d   = table_q;
        match_d   = match_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
`ifdef SWEEP_SCORE_EN
        score_d   = score_q;
`endif
        case (state_q)
            StIdle: begin
                if (bus.start) begin
                    sel_d     = bus.selection_in;
                    target_d  = bus.target;
                    table_d   = 4'b0000;
                    match_d   = 1'b0;
                    idx_d     = 2'd0;
                    gate_in_d = 2'b00;
                    cnt_d     = 4'd0;
                    state_d   = StSettle;
                end
            end
            StSettle: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == CntLast) state_d = StSample;
            end
            StSample: begin
                table_d[idx_q] = bus.gate_out;
                if (idx_q == 2'd3) begin
                    // Compare against the table including the bit captured this cycle
                    match_d = (table_d == target_q);
                    state_d = StDone;
`ifdef SWEEP_SCORE_EN
                    if (match_d && (score_q != 8'hFF)) score_d = score_q + 8'd1;
`endif
                end else begin
                    idx_d     = idx_q + 2'd1;
                    gate_in_d = idx_q + 2'd1;
                    cnt_d     = 4'd0;
                    state_d   = StSettle;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        busy_d = (state_d != StIdle);
        done_d = (state_d == StDone);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            sel_q     <= 4'd0;
            target_q  <= 4'd0;
            gate_in_q <= 2'b00;
            table_q   <= 4'b0000;
            match_q   <= 1'b0;
            idx_q     <= 2'd0;
            cnt_q     <= 4'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef SWEEP_SCORE_EN
            score_q   <= 8'd0;
`endif
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            target_q  <= target_d;
            gate_in_q <= gate_in_d;
            table_q   <= table_d;
            match_q   <= match_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef SWEEP_SCORE_EN
            score_q   <= score_d;
`endif
        end
    end

    assign bus.sel_out     = sel_q;
    assign bus.gate_in     = gate_in_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.truth_table = table_q;
    assign bus.match       = match_q;
`ifdef SWEEP_SCORE_EN
    assign bus.score       = score_q;
`endif

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: time-based reference model plus directed sweeps.
// Score checks are compiled in when SWEEP_SCORE_EN is defined.
module tb_truth_table_sweeper;
    localparam int S = 2;
    localparam int L = 4 * (S + 1);

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;
    bit   chk_en = 1'b0;

    truth_table_sweeper_if bus ();

    truth_table_sweeper #(.SETTLE_CYCLES(S)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Combinational selector model for codes 0..5
    function automatic logic gate_fn(input logic [3:0] code, input logic [1:0] pat);
        logic a, b;
        a = pat[1];
        b = pat[0];
        case (code)
            4'd0:    return a & b;
            4'd1:    return a | b;
            4'd2:    return ~(a & b);
            4'd3:    return ~(a | b);
            4'd4:    return a ^ b;
            4'd5:    return ~(a ^ b);
            default: return 1'b0;
        endcase
    endfunction

    assign bus.gate_out = gate_fn(bus.sel_out, bus.gate_in);

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: everything derives from k = edges since the accepting edge
    bit         m_act;
    int         m_k;
    logic [3:0] m_sel, m_tgt, m_tbl;
    logic [1:0] m_gin;
    logic       m_match;
    int         m_score;

    always @(posedge clk) begin
        if (reset) begin
            m_act = 0; m_k = 0; m_sel = 0; m_tgt = 0; m_tbl = 0; m_gin = 0; m_match = 0;
            m_score = 0;
        end else if (m_act) begin
            m_k++;
            if (m_k > L) begin
                m_act = 0;
            end else begin
                m_gin = 2'((m_k / (S + 1) > 3) ? 3 : m_k / (S + 1));
                for (int j = 0; j < 4; j++)
                    if ((j + 1) * (S + 1) <= m_k) m_tbl[j] = gate_fn(m_sel, 2'(j));
                if (m_k == L) begin
                    m_match = (m_tbl == m_tgt);
                    if (m_match && m_score < 255) m_score++;
                end
            end
        end else if (bus.start) begin
            m_act = 1; m_k = 0; m_sel = bus.selection_in; m_tgt = bus.target;
            m_tbl = 0; m_gin = 0; m_match = 0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", int'(bus.busy), int'(m_act));
            check("done", int'(bus.done), int'(m_act && m_k == L));
            check("sel_out", int'(bus.sel_out), int'(m_sel));
            check("gate_in", int'(bus.gate_in), int'(m_gin));
            check("table", int'(bus.truth_table), int'(m_tbl));
            check("match", int'(bus.match), int'(m_match));
`ifdef SWEEP_SCORE_EN
            check("score", int'(bus.score), m_score);
`endif
        end
    end

    task automatic start_sweep(input logic [3:0] code, input logic [3:0] tgt);
        bus.selection_in = code;
        bus.target       = tgt;
        bus.start        = 1'b1;
        @(negedge clk);
        bus.start        = 1'b0;
    endtask

    // Called right after start_sweep; n counts edges from the accepting edge to done
    task automatic wait_done(input string name, output int n);
        n = 0;
        while (!bus.done && n < 4 * L) begin
            @(negedge clk);
            n++;
        end
        if (!bus.done) check({name, "_timeout"}, 0, 1);
    endtask

    int n, dones;

    initial begin
        bus.start = 0; bus.selection_in = 0; bus.target = 0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk_en = 1'b1;
        check("rst_busy", int'(bus.busy), 0);
        check("rst_table", int'(bus.truth_table), 0);
        check("rst_sel", int'(bus.sel_out), 0);
        check("rst_gate_in", int'(bus.gate_in), 0);

        // AND, matching target
        start_sweep(4'd0, 4'b1000);
        wait_done("and", n);
        check("and_latency", n, 12);
        check("and_table", int'(bus.truth_table), 4'b1000);
        check("and_match", int'(bus.match), 1);
        @(negedge clk);
        check("and_busy_after", int'(bus.busy), 0);
        check("and_done_after", int'(bus.done), 0);

        // XOR, mismatching target
        start_sweep(4'd4, 4'b1001);
        wait_done("xor", n);
        check("xor_table", int'(bus.truth_table), 4'b0110);
        check("xor_match", int'(bus.match), 0);
        repeat (3) @(negedge clk);
        check("xor_sel_hold", int'(bus.sel_out), 4);

        // XOR with a second start mid-sweep
        start_sweep(4'd4, 4'b0110);
        repeat (4) @(negedge clk);
        start_sweep(4'd1, 4'b1110);
        wait_done("xor2", n);
        check("xor2_latency", n + 5, 12);
        check("xor2_table", int'(bus.truth_table), 4'b0110);
        check("xor2_sel", int'(bus.sel_out), 4);
        check("xor2_match", int'(bus.match), 1);
        @(negedge clk);

        // OR aborted by reset, then a clean rerun
        start_sweep(4'd1, 4'b1110);
        repeat (6) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", int'(bus.busy), 0);
        check("abort_table", int'(bus.truth_table), 0);
        check("abort_gate_in", int'(bus.gate_in), 0);
        check("abort_sel", int'(bus.sel_out), 0);
        repeat (2) @(negedge clk);
        start_sweep(4'd1, 4'b1110);
        wait_done("or", n);
        check("or_latency", n, 12);
        check("or_table", int'(bus.truth_table), 4'b1110);
        check("or_match", int'(bus.match), 1);
        @(negedge clk);

        // NAND with start held high: back-to-back sweeps one idle cycle apart
        bus.selection_in = 4'd2;
        bus.target       = 4'b0111;
        bus.start        = 1'b1;
        dones = 0;
        repeat (28) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        bus.start = 1'b0;
        check("nand_dones", dones, 2);
        check("nand_table", int'(bus.truth_table), 4'b0111);
        check("nand_match", int'(bus.match), 1);
        repeat (2) @(negedge clk);

`ifdef SWEEP_SCORE_EN
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("score_rst", int'(bus.score), 0);
        start_sweep(4'd0, 4'b0000);
        wait_done("score_miss0", n);
        @(negedge clk);
        check("score_miss0", int'(bus.score), 0);
        for (int i = 0; i < 254; i++) begin
            start_sweep(4'd0, 4'b1000);
            wait_done("score_loop", n);
            @(negedge clk);
        end
        check("score_254", int'(bus.score), 254);
        start_sweep(4'd0, 4'b1000);
        wait_done("score_255", n);
        @(negedge clk);
        check("score_255", int'(bus.score), 255);
        start_sweep(4'd5, 4'b1001);
        wait_done("score_sat", n);
        @(negedge clk);
        check("score_sat", int'(bus.score), 255);
        start_sweep(4'd4, 4'b1111);
        wait_done("score_miss", n);
        @(negedge clk);
        check("score_miss", int'(bus.score), 255);
`endif

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
- Downstream/driver stage for the gate-selector block.
- On a start pulse, latches a gate selection, then steps the selector's 2-bit input through 00, 01, 10, 11.
- Waits a settle interval per pattern, then samples gate_out into a 4-bit truth table and compares it with a target table.
- Feeds the "identify the gate" game logic and the LEDR display of the result.

Parameters:
- SETTLE_CYCLES, 2, cycles each input pattern is held before sampling; legal range 1..15.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin a sweep; honoured only in IDLE.
- selection_in  input  4  gate code to sweep (0=AND … 8=D latch); latched on an accepted start.
- target  input  4  expected truth table; latched on an accepted start.
- gate_out  input  1  output of the gate selector under test.
- sel_out  output  4  gate code driven to the selector's selection input.
- gate_in  output  2  pattern driven to the selector's in[1:0]; gate_in[1] = in[1].
- busy  output  1  high from the accepted start through the DONE cycle.
- done  output  1  one-cycle pulse: sweep complete, table and match valid.
- table  output  4  captured truth table; bit index = {gate_in[1], gate_in[0]} at sample time.
- match  output  1  table == latched target; valid from done, held until next accepted start.

Behaviour:
- Reset values: state=IDLE, sel_out=0, gate_in=00, busy=0, done=0, table=0000, match=0, internal idx=0, settle counter=0.
- FSM states: IDLE, SETTLE, SAMPLE, DONE.
- IDLE, start=1 at edge:
  - latch sel_out<=selection_in and target;
  - table<=0000, match<=0, idx<=0, gate_in<=00, counter<=0;
  - go to SETTLE.
- SETTLE: counter increments each cycle. After SETTLE_CYCLES cycles in SETTLE, go to SAMPLE.
- SAMPLE (one cycle): at its closing edge, table[idx]<=gate_out.
  - If idx==3: go to DONE and match<=({table with bit 3 updated} == target).
  - Otherwise: idx<=idx+1, gate_in<=idx+1, counter<=0, go to SETTLE.
- DONE: done=1 for exactly one cycle, busy=1; next state IDLE. start in DONE is ignored.
- Latency: each pattern occupies SETTLE_CYCLES+1 cycles. done is high in the cycle 4*(SETTLE_CYCLES+1) edges after the edge that accepted start (12 for the default).
- Outputs are registered. gate_in changes only on an accepted start or on a SAMPLE→SETTLE edge.
- sel_out holds its value after DONE until the next accepted start; a latching selector keeps its mode between sweeps.
- Pattern order is fixed at 00,01,10,11. Stateful selector modes (SR, T, D) are sampled as-is; no pre-clear.
- start while busy: ignored; no restart, latched values unchanged.
- selection_in/target changes mid-sweep: no effect.
- reset asserted in any state, including mid-sweep: next state IDLE with all reset values; reset has priority over start on the same edge.
- The counter is wide enough for 15; the idx compare is exact 2-bit, no wrap-around.

Optional Feature:
- Macro: SWEEP_SCORE_EN.
- Defined: adds output score[7:0].
  - Reset 0.
  - Increments by 1 on the edge entering DONE when the computed match is 1.
  - Saturates at 255 with no wrap.
  - Not cleared by start.
- Undefined: no score port, register, or logic.

Test Plan:
- Bench models the selector combinationally for codes 0-5. selection_in=0 (AND), target=1000, SETTLE_CYCLES=2, start pulse → gate_in sequence 00,01,10,11, each held 3 cycles; done pulse 12 edges after start; table=1000; match=1; busy low the cycle after done.
- selection_in=4 (XOR), target=1001 → table=0110, match=0, done pulses once; sel_out stays 4 after done.
- Start XOR sweep, pulse start again at cycle 5 with selection_in=1 → ignored; result table=0110, sel_out=4 throughout.
- Start OR sweep, assert reset at cycle 7 → next cycle: busy=0, table=0000, gate_in=00, sel_out=0; no done pulse; a fresh start then completes normally with table=1110.
- start held high continuously with selection_in=2 (NAND) → sweeps of 12 cycles separated by one IDLE cycle; each gives table=0111 and a single done pulse.
- SWEEP_SCORE_EN defined: force score to 254, run two matching sweeps → score 255 after the first, stays 255 after the second; a mismatching sweep leaves score unchanged.
